mcr_ram_ctl: RTL and testbench

Microcode RAM controller: responder for the IRAM's external-RAM mode. It serves microinstruction fetch, prefetch and write requests (14-bit PC, 49-bit word) from a 16-bit asynchronous SRAM, moving each word as four 16-bit beats. It sits at the top level between the IRAM fetch/prefetch strobes and the board SRAM pins.

---
 rtl/mcr_pkg.sv | 30 +++
 rtl/mcr_prefetch_buf.sv | 39 +++
 rtl/mcr_ram_ctl.sv | 148 ++++++++++++++
 tb/tb_mcr_ram_ctl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcr_pkg.sv
// Shared types and sizes for the microcode RAM controller.
// Word slicing helper maps a 49-bit microword onto four 16-bit SRAM beats.
package mcr_pkg;

    localparam int MCR_BEATS = 4;
    localparam int MCR_AW    = 14;
    localparam int MCR_DW    = 49;
    localparam int SRAM_DW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } mcr_state_t;

    // Beat 3 carries only bit 48; its upper bits go out as zero.
    function automatic logic [SRAM_DW-1:0] beat_slice(input logic [MCR_DW-1:0] word,
                                                      input logic [1:0]        beat);
        logic [SRAM_DW-1:0] res;
        case (beat)
            2'd0:    res = word[15:0];
            2'd1:    res = word[31:16];
            2'd2:    res = word[47:32];
            default: res = {15'b0, word[48]};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mcr_prefetch_buf.sv
// One-entry microword buffer: tag/valid/data with lookup, fill and invalidate.
// Only instantiated when MCR_PREFETCH_BUF_EN is defined.
module mcr_prefetch_buf
    import mcr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [MCR_AW-1:0] lookup_addr,
    output logic              hit,
    output logic [MCR_DW-1:0] hit_data,
    input  logic              fill_en,
    input  logic [MCR_AW-1:0] fill_tag,
    input  logic [MCR_DW-1:0] fill_data,
    input  logic              inval_en
);

    logic              valid_reg;
    logic [MCR_AW-1:0] tag_reg;
    logic [MCR_DW-1:0] data_reg;

    assign hit      = valid_reg && (tag_reg == lookup_addr);
    assign hit_data = data_reg;

    // Fill and invalidate come from different controller states, never together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= '0;
        end else if (fill_en) begin
            valid_reg <= 1'b1;
            tag_reg   <= fill_tag;
            data_reg  <= fill_data;
        end else if (inval_en && hit) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/mcr_ram_ctl.sv
// Microcode RAM controller: serves IRAM fetch/prefetch/write over a 16-bit async SRAM in four beats.
// Optional one-entry prefetch buffer is enabled by defining MCR_PREFETCH_BUF_EN.
module mcr_ram_ctl
    import mcr_pkg::*;
#(
    parameter int SRAM_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MCR_AW-1:0]  mcr_addr,
    input  logic               mcr_fetch,
    input  logic               mcr_prefetch,
    input  logic               mcr_write,
    input  logic [MCR_DW-1:0]  mcr_data_out,
    output logic [MCR_DW-1:0]  mcr_data_in,
    output logic               mcr_ready,
    output logic [15:0]        sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    mcr_state_t        state_reg;
    logic [1:0]        beat_reg;
    logic [2:0]        wait_reg;
    logic [2:0]        wait_next;
    logic [MCR_AW-1:0] addr_reg;
    logic [MCR_DW-1:0] wdata_reg;
    logic              pf_reg;
    logic [47:0]       rd_shift_reg;
    logic              beat_last;
    logic              buf_hit;
    logic              prefetch_req;
    logic [MCR_DW-1:0] buf_data;

    assign wait_next = wait_reg + 3'd1;
    assign beat_last = (wait_reg == 3'(SRAM_WAIT));

`ifdef MCR_PREFETCH_BUF_EN
    logic fill_en;
    logic inval_en;

    // Every completed read refreshes the buffer, so fill taps the last beat directly.
    assign fill_en  = (state_reg == ST_RD) && beat_last && (beat_reg == 2'd3);
    assign inval_en = (state_reg == ST_IDLE) && mcr_fetch && mcr_write;

    mcr_prefetch_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .lookup_addr(mcr_addr),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .fill_en    (fill_en),
        .fill_tag   (addr_reg),
        .fill_data  ({sram_dq_in[0], rd_shift_reg}),
        .inval_en   (inval_en)
    );

    assign prefetch_req = mcr_prefetch && !buf_hit;
`else
    assign buf_hit      = 1'b0;
    assign buf_data     = '0;
    assign prefetch_req = mcr_prefetch & 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            beat_reg     <= 2'd0;
            wait_reg     <= 3'd0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            pf_reg       <= 1'b0;
            rd_shift_reg <= '0;
            mcr_data_in  <= '0;
            mcr_ready    <= 1'b0;
            sram_addr    <= '0;
            sram_dq_out  <= '0;
            sram_dq_oe   <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
        end else begin
            mcr_ready <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    addr_reg  <= mcr_addr;
                    wdata_reg <= mcr_data_out;
                    beat_reg  <= 2'd0;
                    wait_reg  <= 3'd0;
                    sram_addr <= {mcr_addr, 2'd0};
                    if (mcr_fetch && mcr_write) begin
                        state_reg   <= ST_WR;
                        sram_ce_n   <= 1'b0;
                        sram_we_n   <= 1'b0;
                        sram_dq_oe  <= 1'b1;
                        sram_dq_out <= beat_slice(mcr_data_out, 2'd0);
                    end else if (mcr_fetch && buf_hit) begin
                        state_reg   <= ST_DONE;
                        mcr_ready   <= 1'b1;
                        mcr_data_in <= buf_data;
                    end else if (mcr_fetch || prefetch_req) begin
                        state_reg <= ST_RD;
                        pf_reg    <= !mcr_fetch;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                    end
                end
                ST_RD, ST_WR: begin
                    if (!beat_last) begin
                        wait_reg  <= wait_next;
                        // Release we_n one cycle early so the beat ends with data still held.
                        sram_we_n <= (state_reg == ST_RD) || (wait_next == 3'(SRAM_WAIT));
                    end else begin
                        if (state_reg == ST_RD) begin
                            case (beat_reg)
                                2'd0:    rd_shift_reg[15:0]  <= sram_dq_in;
                                2'd1:    rd_shift_reg[31:16] <= sram_dq_in;
                                2'd2:    rd_shift_reg[47:32] <= sram_dq_in;
                                default: if (!pf_reg) mcr_data_in <= {sram_dq_in[0], rd_shift_reg};
                            endcase
                        end
                        if (beat_reg == 2'd3) begin
                            state_reg  <= ST_DONE;
                            mcr_ready  <= (state_reg == ST_WR) || !pf_reg;
                            sram_ce_n  <= 1'b1;
                            sram_oe_n  <= 1'b1;
                            sram_we_n  <= 1'b1;
                            sram_dq_oe <= 1'b0;
                        end else begin
                            beat_reg    <= beat_reg + 2'd1;
                            wait_reg    <= 3'd0;
                            sram_addr   <= {addr_reg, beat_reg + 2'd1};
                            sram_dq_out <= beat_slice(wdata_reg, beat_reg + 2'd1);
                            sram_we_n   <= (state_reg == ST_RD);
                        end
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcr_ram_ctl.sv
// Self-checking bench for mcr_ram_ctl: word-level memory model, randomized traffic,
// plus a second instance with SRAM_WAIT=3. Buffer scenarios follow MCR_PREFETCH_BUF_EN.
module tb_mcr_ram_ctl;

`ifdef MCR_PREFETCH_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [13:0] mcr_addr = '0;
    logic        mcr_fetch = 1'b0, mcr_prefetch = 1'b0, mcr_write = 1'b0;
    logic [48:0] mcr_data_out = '0;
    logic [48:0] mcr_data_in;
    logic        mcr_ready;
    logic [15:0] sram_addr, sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [13:0] b_addr = '0;
    logic        b_fetch = 1'b0;
    logic [48:0] b_data_in;
    logic        b_ready;
    logic [15:0] b_sram_addr, b_sram_dq_out, b_sram_dq_in;
    logic        b_dq_oe, b_ce_n, b_oe_n, b_we_n;

    int total = 0;
    int bad   = 0;

    logic [48:0] model [logic [13:0]];
    bit          pb_valid = 1'b0;
    logic [13:0] pb_tag   = '0;
    logic [48:0] last_rd  = '0;

    bit [15:0] mem_a [65536];
    bit        wr_a  [65536];

    always #5 clk = ~clk;

    mcr_ram_ctl #(.SRAM_WAIT(1)) dut (
        .clk(clk), .reset(reset), .mcr_addr(mcr_addr), .mcr_fetch(mcr_fetch),
        .mcr_prefetch(mcr_prefetch), .mcr_write(mcr_write), .mcr_data_out(mcr_data_out),
        .mcr_data_in(mcr_data_in), .mcr_ready(mcr_ready), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    mcr_ram_ctl #(.SRAM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .mcr_addr(b_addr), .mcr_fetch(b_fetch),
        .mcr_prefetch(1'b0), .mcr_write(1'b0), .mcr_data_out(49'h0),
        .mcr_data_in(b_data_in), .mcr_ready(b_ready), .sram_addr(b_sram_addr),
        .sram_dq_out(b_sram_dq_out), .sram_dq_in(b_sram_dq_in), .sram_dq_oe(b_dq_oe),
        .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n)
    );

    function automatic logic [15:0] init_pat(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Expected 49-bit word: last written value, else assembled from the power-up pattern.
    function automatic logic [48:0] exp_word(input logic [13:0] a);
        logic [15:0] w0, w1, w2, w3;
        if (model.exists(a)) return model[a];
        w0 = init_pat({a, 2'd0});
        w1 = init_pat({a, 2'd1});
        w2 = init_pat({a, 2'd2});
        w3 = init_pat({a, 2'd3});
        return {w3[0], w2, w1, w0};
    endfunction

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            mem_a[sram_addr] <= sram_dq_out;
            wr_a[sram_addr]  <= 1'b1;
        end
    end

    always_comb begin
        sram_dq_in = 16'hDEAD;
        if (!sram_ce_n && !sram_oe_n)
            sram_dq_in = wr_a[sram_addr] ? mem_a[sram_addr] : init_pat(sram_addr);
        b_sram_dq_in = 16'hDEAD;
        if (!b_ce_n && !b_oe_n)
            b_sram_dq_in = init_pat(b_sram_addr);
    end

    task automatic do_req(input bit wr, input bit pf, input logic [13:0] a, input logic [48:0] d,
                          output int lat, output int acc, output logic rdy_after);
        @(negedge clk);
        mcr_addr = a; mcr_fetch = 1'b1; mcr_write = wr; mcr_prefetch = pf; mcr_data_out = d;
        lat = 0; acc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (!sram_ce_n) acc++;
            if (mcr_ready) begin
                lat = n;
                break;
            end
        end
        mcr_fetch = 1'b0; mcr_write = 1'b0; mcr_prefetch = 1'b0;
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL req_timeout addr=%h got no ready within 40 cycles", a);
        end
        @(posedge clk); #1;
        rdy_after = mcr_ready;
    endtask

    task automatic issue_pf(input logic [13:0] a, output int acc, output int rdy);
        @(negedge clk);
        mcr_addr = a; mcr_prefetch = 1'b1; mcr_fetch = 1'b0; mcr_write = 1'b0;
        acc = 0; rdy = 0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            if (n == 1) mcr_prefetch = 1'b0;
            if (!sram_ce_n) acc++;
            if (mcr_ready) rdy++;
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({mcr_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 5'b01110) begin
            bad++;
            $display("FAIL reset_strobes got=%b exp=01110",
                     {mcr_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        total++;
        if (mcr_data_in !== 49'h0 || sram_addr !== 16'h0 || sram_dq_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_data data_in=%h addr=%h dq_out=%h exp all 0",
                     mcr_data_in, sram_addr, sram_dq_out);
        end
        @(negedge clk);
        reset = 1'b1;
        $display("reset released: data_in=%h ready=%b", mcr_data_in, mcr_ready);
    endtask

    task automatic test_write_read();
        int lat, acc;
        logic ra;
        logic [48:0] w = 49'h1_2345_6789_ABCD;
        do_req(1'b1, 1'b0, 14'h0123, w, lat, acc, ra);
        model[14'h0123] = w;
        if (pb_valid && pb_tag == 14'h0123) pb_valid = 1'b0;
        $display("write addr=0123 data=%h lat=%0d acc=%0d", w, lat, acc);
        total++;
        if (lat !== 10'd9 || ra !== 1'b0) begin
            bad++; $display("FAIL write_latency got=%0d after=%b exp=9 after=0", lat, ra);
        end
        total++;
        if ({mem_a[16'h048C], mem_a[16'h048D], mem_a[16'h048E], mem_a[16'h048F]} !== 64'hABCD_6789_2345_0001) begin
            bad++;
            $display("FAIL write_beats got=%h %h %h %h exp=ABCD 6789 2345 0001",
                     mem_a[16'h048C], mem_a[16'h048D], mem_a[16'h048E], mem_a[16'h048F]);
        end
        do_req(1'b0, 1'b0, 14'h0123, 49'h0, lat, acc, ra);
        $display("fetch addr=0123 data=%h lat=%0d acc=%0d", mcr_data_in, lat, acc);
        total++;
        if (mcr_data_in !== w) begin
            bad++; $display("FAIL fetch_data got=%h exp=%h", mcr_data_in, w);
        end
        total++;
        if (lat != 9 || ra !== 1'b0 || acc != 8) begin
            bad++; $display("FAIL fetch_latency got=%0d acc=%0d after=%b exp=9 acc=8 after=0", lat, acc, ra);
        end
        last_rd = w;
        if (BUF) begin pb_valid = 1'b1; pb_tag = 14'h0123; end
    endtask

    task automatic test_reset_mid();
        int lat, acc;
        logic ra;
        bit seen = 1'b0;
        @(negedge clk);
        mcr_addr = 14'h3000; mcr_fetch = 1'b1; mcr_write = 1'b1; mcr_data_out = 49'h0_FFFF_FFFF_FFFF;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (!sram_ce_n && sram_addr[1:0] == 2'd2) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL reset_mid_beat2 got=not_seen exp=seen"); end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({mcr_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 5'b01110 || mcr_data_in !== 49'h0) begin
            bad++;
            $display("FAIL reset_mid got=%b data=%h exp=01110 data=0",
                     {mcr_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, mcr_data_in);
        end
        mcr_fetch = 1'b0; mcr_write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pb_valid = 1'b0;
        last_rd = '0;
        $display("reset mid-write: strobes high, data_in=%h", mcr_data_in);
        do_req(1'b0, 1'b0, 14'h0123, 49'h0, lat, acc, ra);
        $display("fetch after reset addr=0123 data=%h lat=%0d", mcr_data_in, lat);
        total++;
        if (lat != 9 || mcr_data_in !== exp_word(14'h0123)) begin
            bad++; $display("FAIL post_reset_fetch lat=%0d data=%h exp lat=9 data=%h",
                            lat, mcr_data_in, exp_word(14'h0123));
        end
        last_rd = exp_word(14'h0123);
        if (BUF) begin pb_valid = 1'b1; pb_tag = 14'h0123; end
    endtask

    task automatic test_fetch_prefetch();
        int lat, acc, idle_acc = 0;
        logic ra;
        do_req(1'b0, 1'b1, 14'h0345, 49'h0, lat, acc, ra);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (!sram_ce_n) idle_acc++;
        end
        $display("fetch+prefetch addr=0345 data=%h lat=%0d later_acc=%0d", mcr_data_in, lat, idle_acc);
        total++;
        if (lat != 9 || mcr_data_in !== exp_word(14'h0345)) begin
            bad++; $display("FAIL fetch_over_prefetch lat=%0d data=%h exp lat=9 data=%h",
                            lat, mcr_data_in, exp_word(14'h0345));
        end
        total++;
        if (idle_acc != 0) begin
            bad++; $display("FAIL stray_prefetch got acc=%0d exp=0", idle_acc);
        end
        last_rd = exp_word(14'h0345);
        if (BUF) begin pb_valid = 1'b1; pb_tag = 14'h0345; end
    endtask

    task automatic test_prefetch();
        int lat, acc, rdy;
        logic ra;
        logic [48:0] w;
        issue_pf(14'h0200, acc, rdy);
        $display("prefetch addr=0200 acc=%0d ready_pulses=%0d", acc, rdy);
        total++;
        if (acc != (BUF ? 8 : 0) || rdy != 0 || mcr_data_in !== last_rd) begin
            bad++; $display("FAIL prefetch_issue acc=%0d rdy=%0d data=%h exp acc=%0d rdy=0 data=%h",
                            acc, rdy, mcr_data_in, BUF ? 8 : 0, last_rd);
        end
        if (BUF) begin pb_valid = 1'b1; pb_tag = 14'h0200; end
`ifdef MCR_PREFETCH_BUF_EN
        do_req(1'b0, 1'b0, 14'h0200, 49'h0, lat, acc, ra);
        $display("fetch hit addr=0200 data=%h lat=%0d acc=%0d", mcr_data_in, lat, acc);
        total++;
        if (lat != 1 || acc != 0 || ra !== 1'b0 || mcr_data_in !== exp_word(14'h0200)) begin
            bad++; $display("FAIL buffer_hit lat=%0d acc=%0d data=%h exp lat=1 acc=0 data=%h",
                            lat, acc, mcr_data_in, exp_word(14'h0200));
        end
        w = {17'($urandom), $urandom};
        do_req(1'b1, 1'b0, 14'h0200, w, lat, acc, ra);
        model[14'h0200] = w;
        pb_valid = 1'b0;
        do_req(1'b0, 1'b0, 14'h0200, 49'h0, lat, acc, ra);
        $display("fetch after write addr=0200 data=%h lat=%0d acc=%0d", mcr_data_in, lat, acc);
        total++;
        if (lat != 9 || acc != 8 || mcr_data_in !== w) begin
            bad++; $display("FAIL buffer_invalidate lat=%0d acc=%0d data=%h exp lat=9 acc=8 data=%h",
                            lat, acc, mcr_data_in, w);
        end
        pb_valid = 1'b1; pb_tag = 14'h0200;
        last_rd = w;
`endif
    endtask

    task automatic test_random();
        int lat, acc, rdy, op, exp_lat, exp_acc;
        logic ra;
        logic [13:0] a;
        logic [48:0] d;
        bit hit;
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 2);
            a  = 14'h0800 + 14'($urandom_range(0, 7) * 37);
            d  = {17'($urandom), $urandom};
            hit = BUF && pb_valid && pb_tag == a;
            if (op == 0) begin
                do_req(1'b1, 1'b0, a, d, lat, acc, ra);
                model[a] = d;
                if (hit) pb_valid = 1'b0;
                $display("rand[%0d] write addr=%h data=%h lat=%0d", i, a, d, lat);
                total++;
                if (lat != 9 || acc != 8 || ra !== 1'b0) begin
                    bad++; $display("FAIL rand_write[%0d] lat=%0d acc=%0d exp 9/8", i, lat, acc);
                end
            end else if (op == 1) begin
                do_req(1'b0, 1'b0, a, 49'h0, lat, acc, ra);
                exp_lat = hit ? 1 : 9;
                exp_acc = hit ? 0 : 8;
                $display("rand[%0d] fetch addr=%h data=%h lat=%0d", i, a, mcr_data_in, lat);
                total++;
                if (lat != exp_lat || acc != exp_acc || ra !== 1'b0 || mcr_data_in !== exp_word(a)) begin
                    bad++; $display("FAIL rand_fetch[%0d] lat=%0d acc=%0d data=%h exp lat=%0d acc=%0d data=%h",
                                    i, lat, acc, mcr_data_in, exp_lat, exp_acc, exp_word(a));
                end
                last_rd = exp_word(a);
                if (BUF) begin pb_valid = 1'b1; pb_tag = a; end
            end else begin
                issue_pf(a, acc, rdy);
                exp_acc = (BUF && !hit) ? 8 : 0;
                $display("rand[%0d] prefetch addr=%h acc=%0d", i, a, acc);
                total++;
                if (acc != exp_acc || rdy != 0 || mcr_data_in !== last_rd) begin
                    bad++; $display("FAIL rand_prefetch[%0d] acc=%0d rdy=%0d data=%h exp acc=%0d rdy=0 data=%h",
                                    i, acc, rdy, mcr_data_in, exp_acc, last_rd);
                end
                if (BUF) begin pb_valid = 1'b1; pb_tag = a; end
            end
        end
    endtask

    task automatic test_wait3();
        logic [15:0] q[$];
        int lat = 0, misplaced = 0, wr_cycles = 0;
        logic [15:0] exp_a;
        @(negedge clk);
        b_addr = 14'h3FFF; b_fetch = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (!b_ce_n) q.push_back(b_sram_addr);
            if (!b_we_n || b_dq_oe) wr_cycles++;
            if (b_ready) begin lat = n; break; end
        end
        b_fetch = 1'b0;
        $display("wait3 fetch addr=3FFF data=%h lat=%0d beats_cycles=%0d", b_data_in, lat, q.size());
        total++;
        if (lat != 17 || q.size() != 16) begin
            bad++; $display("FAIL wait3_latency lat=%0d cycles=%0d exp 17/16", lat, q.size());
        end
        for (int i = 0; i < q.size() && i < 16; i++) begin
            exp_a = {14'h3FFF, 2'(i / 4)};
            if (q[i] !== exp_a) misplaced++;
        end
        total++;
        if (misplaced != 0 || wr_cycles != 0) begin
            bad++; $display("FAIL wait3_addr_seq misplaced=%0d write_cycles=%0d exp 0/0", misplaced, wr_cycles);
        end
        total++;
        if (b_data_in !== exp_word(14'h3FFF)) begin
            bad++; $display("FAIL wait3_data got=%h exp=%h", b_data_in, exp_word(14'h3FFF));
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_mid();
        test_fetch_prefetch();
        test_prefetch();
        test_random();
        test_wait3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
